// File: rtl/pps_lock_tracker_if.sv
// Bus bundle for pps_lock_tracker: PPS flag, seconds load and status clear in;
// timestamp, period and lock status out.
interface pps_lock_tracker_if #(
   parameter int COUNT_WIDTH = 32
);
   logic                   pps_flag_i;
   logic [31:0]            sec_load_i;
   logic                   sec_load_wr_i;
   logic                   status_clr_i;
   logic [31:0]            seconds_o;
   logic [COUNT_WIDTH-1:0] subsec_o;
   logic [COUNT_WIDTH-1:0] last_period_o;
   logic                   pps_event_o;
   logic                   locked_o;
   logic [1:0]             status_o;

   modport master (
      output pps_flag_i, sec_load_i, sec_load_wr_i, status_clr_i,
      input  seconds_o, subsec_o, last_period_o, pps_event_o, locked_o, status_o
   );

   modport slave (
      input  pps_flag_i, sec_load_i, sec_load_wr_i, status_clr_i,
      output seconds_o, subsec_o, last_period_o, pps_event_o, locked_o, status_o
   );
endinterface

// File: rtl/pps_lock_tracker.sv
// Measures PPS periods, keeps seconds/sub-second time and qualifies the PPS
// against a nominal period with a NOREF/ACQUIRE/LOCKED state machine.
module pps_lock_tracker #(
   parameter int NOMINAL_PERIOD = 125000000,
   parameter int TOLERANCE      = 1000,
   parameter int LOCK_COUNT     = 4,
   parameter int COUNT_WIDTH    = 32
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   pps_lock_tracker_if.slave   bus
);

   typedef enum logic [1:0] {
      NOREF   = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] MIN_PERIOD  = COUNT_WIDTH'(NOMINAL_PERIOD - TOLERANCE);
   localparam logic [COUNT_WIDTH-1:0] MAX_PERIOD  = COUNT_WIDTH'(NOMINAL_PERIOD + TOLERANCE);
   localparam logic [3:0]             LOCK_TARGET = 4'(LOCK_COUNT);

   state_t                 state_q;
   logic [3:0]             goodCnt_q;
   logic                   locked_q;
   logic [COUNT_WIDTH-1:0] subsec_q;
   logic [COUNT_WIDTH-1:0] lastPeriod_q;
   logic [31:0]            seconds_q;
   logic                   ppsEvent_q;
   logic                   pending_q;
   logic [31:0]            pendVal_q;
   logic [1:0]             status_q;

   logic [COUNT_WIDTH-1:0] period_d;
   logic                   periodGood;
   logic                   timeout;
   logic [1:0]             statusSet;
   logic [1:0]             status_d;

   // The subsec value is sampled before it clears, so +1 gives the flag-to-flag distance.
   always_comb begin
      period_d   = subsec_q + COUNT_WIDTH'(1);
      periodGood = (period_d >= MIN_PERIOD) && (period_d <= MAX_PERIOD);
      timeout    = (state_q != NOREF) && (subsec_q == MAX_PERIOD) && !bus.pps_flag_i;
      statusSet  = {bus.pps_flag_i && (state_q != NOREF) && !periodGood, timeout};
      status_d   = (bus.status_clr_i ? 2'b00 : status_q) | statusSet;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= NOREF;
         goodCnt_q    <= '0;
         locked_q     <= 1'b0;
         subsec_q     <= '0;
         lastPeriod_q <= '0;
         seconds_q    <= '0;
         ppsEvent_q   <= 1'b0;
         pending_q    <= 1'b0;
         pendVal_q    <= '0;
         status_q     <= '0;
      end else begin
         ppsEvent_q <= bus.pps_flag_i;
         status_q   <= status_d;

         if (bus.pps_flag_i) begin
            subsec_q     <= '0;
            lastPeriod_q <= period_d;
            seconds_q    <= pending_q ? pendVal_q : seconds_q + 32'd1;
            pending_q    <= 1'b0;
         end else if (subsec_q != '1) begin
            subsec_q <= subsec_q + COUNT_WIDTH'(1);
         end

         // A write in the flag cycle lands after the flag consumed the old value.
         if (bus.sec_load_wr_i) begin
            pendVal_q <= bus.sec_load_i;
            pending_q <= 1'b1;
         end

         unique case (state_q)
            NOREF: begin
               if (bus.pps_flag_i) begin
                  state_q   <= ACQUIRE;
                  goodCnt_q <= '0;
                  locked_q  <= 1'b0;
               end
            end
            ACQUIRE: begin
               if (bus.pps_flag_i) begin
                  if (!periodGood) begin
                     goodCnt_q <= '0;
                  end else if (goodCnt_q + 4'd1 == LOCK_TARGET) begin
                     state_q   <= LOCKED;
                     locked_q  <= 1'b1;
                     goodCnt_q <= '0;
                  end else begin
                     goodCnt_q <= goodCnt_q + 4'd1;
                  end
               end else if (timeout) begin
                  state_q   <= NOREF;
                  goodCnt_q <= '0;
                  locked_q  <= 1'b0;
               end
            end
            LOCKED: begin
               if (bus.pps_flag_i && !periodGood) begin
                  state_q   <= ACQUIRE;
                  goodCnt_q <= '0;
                  locked_q  <= 1'b0;
               end else if (timeout) begin
                  state_q   <= NOREF;
                  goodCnt_q <= '0;
                  locked_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= NOREF;
               goodCnt_q <= '0;
               locked_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.seconds_o     = seconds_q;
   assign bus.subsec_o      = subsec_q;
   assign bus.last_period_o = lastPeriod_q;
   assign bus.pps_event_o   = ppsEvent_q;
   assign bus.locked_o      = locked_q;
   assign bus.status_o      = status_q;

endmodule

// File: tb/tb_pps_lock_tracker.sv
// Self-checking bench for pps_lock_tracker: period table, hand-written corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_pps_lock_tracker;

   localparam int NOM = 100;
   localparam int TOL = 2;
   localparam int LC  = 3;
   localparam int CW  = 16;

   logic clk;
   logic rst_n;
   int   checkCount = 0;
   int   passCount  = 0;

   pps_lock_tracker_if #(.COUNT_WIDTH(CW)) ifc ();

   pps_lock_tracker #(
      .NOMINAL_PERIOD(NOM),
      .TOLERANCE     (TOL),
      .LOCK_COUNT    (LC),
      .COUNT_WIDTH   (CW)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: mode 0 = no reference, 1 = acquiring, 2 = locked.
   int          mMode;
   int          mGood;
   logic [31:0] mSeconds;
   logic [31:0] mPendVal;
   bit          mPending;
   logic [CW-1:0] mSubsec;
   logic [CW-1:0] mLastP;
   bit          mEvent;
   logic [1:0]  mStatus;

   task automatic modelReset();
      mMode = 0; mGood = 0; mSeconds = '0; mPendVal = '0; mPending = 0;
      mSubsec = '0; mLastP = '0; mEvent = 0; mStatus = '0;
   endtask

   task automatic modelStep(input logic flag, input logic wr, input logic [31:0] val,
                            input logic clr);
      int p;
      logic [1:0] setBits;
      p = int'(mSubsec) + 1;
      setBits = 2'b00;
      if (flag) begin
         mLastP = CW'(p);
         mEvent = 1;
         if (mPending) mSeconds = mPendVal;
         else          mSeconds = mSeconds + 32'd1;
         mPending = 0;
         if (mMode == 0) begin
            mMode = 1;
            mGood = 0;
         end else if (p >= NOM - TOL && p <= NOM + TOL) begin
            mGood++;
            if (mMode == 1 && mGood >= LC) mMode = 2;
         end else begin
            mMode = 1;
            mGood = 0;
            setBits[1] = 1'b1;
         end
         mSubsec = '0;
      end else begin
         mEvent = 0;
         if (mMode != 0 && int'(mSubsec) == NOM + TOL) begin
            mMode = 0;
            setBits[0] = 1'b1;
         end
         if (mSubsec != '1) mSubsec = mSubsec + 1'b1;
      end
      if (wr) begin
         mPending = 1;
         mPendVal = val;
      end
      mStatus = (clr ? 2'b00 : mStatus) | setBits;
   endtask

   function automatic logic [67:0] dutOutputs();
      return {ifc.seconds_o, ifc.subsec_o, ifc.last_period_o,
              ifc.pps_event_o, ifc.locked_o, ifc.status_o};
   endfunction

   task automatic checkValue(input string name, input logic [67:0] actual,
                             input logic [67:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
   endtask

   task automatic checkOutput();
      logic [67:0] expected;
      expected = {mSeconds, mSubsec, mLastP, mEvent, (mMode == 2), mStatus};
      checkValue("model_cycle", dutOutputs(), expected);
   endtask

   task automatic applyStimulus(input logic flag, input logic wr, input logic [31:0] val,
                                input logic clr);
      ifc.pps_flag_i    = flag;
      ifc.sec_load_wr_i = wr;
      ifc.sec_load_i    = val;
      ifc.status_clr_i  = clr;
      modelStep(flag, wr, val, clr);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic runGap(input int gap, input logic clr, input logic wrFlag,
                         input logic [31:0] val);
      for (int i = 1; i < gap; i++) applyStimulus(1'b0, 1'b0, 32'h0, (i == 1) ? clr : 1'b0);
      applyStimulus(1'b1, wrFlag, val, 1'b0);
   endtask

   typedef struct {
      int          gap;
      logic        clr;
      logic        expLocked;
      logic [1:0]  expStatus;
      logic [31:0] expSeconds;
      int          expPeriod;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{100, 1'b0, 1'b0, 2'b00, 32'd1,  100};
      vecs[1]  = '{100, 1'b0, 1'b0, 2'b00, 32'd2,  100};
      vecs[2]  = '{100, 1'b0, 1'b0, 2'b00, 32'd3,  100};
      vecs[3]  = '{100, 1'b0, 1'b1, 2'b00, 32'd4,  100};
      vecs[4]  = '{ 90, 1'b0, 1'b0, 2'b10, 32'd5,   90};
      vecs[5]  = '{100, 1'b0, 1'b0, 2'b10, 32'd6,  100};
      vecs[6]  = '{100, 1'b0, 1'b0, 2'b10, 32'd7,  100};
      vecs[7]  = '{100, 1'b0, 1'b1, 2'b10, 32'd8,  100};
      vecs[8]  = '{ 98, 1'b1, 1'b1, 2'b00, 32'd9,   98};
      vecs[9]  = '{102, 1'b0, 1'b1, 2'b00, 32'd10, 102};
      vecs[10] = '{103, 1'b0, 1'b0, 2'b10, 32'd11, 103};

      rst_n = 1'b0;
      ifc.pps_flag_i = 1'b0; ifc.sec_load_wr_i = 1'b0;
      ifc.sec_load_i = '0;   ifc.status_clr_i = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkValue("reset_state", dutOutputs(), 68'h0);

      // Period table from reset: acquire, lock, bad period, re-lock, boundaries.
      for (int i = 0; i < 11; i++) begin
         runGap(vecs[i].gap, vecs[i].clr, 1'b0, 32'h0);
         checkValue($sformatf("tbl%0d_locked", i), 68'(ifc.locked_o), 68'(vecs[i].expLocked));
         checkValue($sformatf("tbl%0d_status", i), 68'(ifc.status_o), 68'(vecs[i].expStatus));
         checkValue($sformatf("tbl%0d_seconds", i), 68'(ifc.seconds_o), 68'(vecs[i].expSeconds));
         checkValue($sformatf("tbl%0d_period", i), 68'(ifc.last_period_o), 68'(vecs[i].expPeriod));
         checkValue($sformatf("tbl%0d_event", i), 68'(ifc.pps_event_o), 68'd1);
      end

      // Re-lock, then let flags stop; clear coincides with the timeout cycle.
      repeat (3) runGap(100, 1'b0, 1'b0, 32'h0);
      checkValue("relock", 68'(ifc.locked_o), 68'd1);
      for (int i = 0; i < 102; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkValue("pre_timeout_subsec", 68'(ifc.subsec_o), 68'd102);
      checkValue("pre_timeout_locked", 68'(ifc.locked_o), 68'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkValue("timeout_locked", 68'(ifc.locked_o), 68'd0);
      checkValue("timeout_status_clr", 68'(ifc.status_o), 68'b01);
      checkValue("timeout_subsec_runs", 68'(ifc.subsec_o), 68'd103);
      runGap(20, 1'b0, 1'b0, 32'h0);
      checkValue("after_timeout_status", 68'(ifc.status_o), 68'b01);
      repeat (2) runGap(100, 1'b0, 1'b0, 32'h0);
      checkValue("acq_two_good", 68'(ifc.locked_o), 68'd0);
      runGap(100, 1'b0, 1'b0, 32'h0);
      checkValue("acq_third_good", 68'(ifc.locked_o), 68'd1);

      // Seconds load: mid-period write, coincident write, and 32-bit wrap.
      for (int i = 0; i < 99; i++)
         applyStimulus(1'b0, (i == 40), 32'h1234, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkValue("load_1234", 68'(ifc.seconds_o), 68'h1234);
      runGap(100, 1'b0, 1'b1, 32'hFFFF_FFFF);
      checkValue("coincident_write_incr", 68'(ifc.seconds_o), 68'h1235);
      runGap(100, 1'b0, 1'b0, 32'h0);
      checkValue("coincident_write_load", 68'(ifc.seconds_o), 68'hFFFF_FFFF);
      runGap(100, 1'b0, 1'b0, 32'h0);
      checkValue("seconds_wrap", 68'(ifc.seconds_o), 68'h0);

      // Back-to-back flags give P=1, a bad period, and two event pulses.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      runGap(50, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkValue("b2b_period", 68'(ifc.last_period_o), 68'd1);
      checkValue("b2b_event", 68'(ifc.pps_event_o), 68'd1);
      checkValue("b2b_status", 68'(ifc.status_o), 68'b10);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkValue("b2b_event_drops", 68'(ifc.pps_event_o), 68'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 60; n++) begin
         int r;
         int gap;
         r = int'($urandom_range(0, 9));
         if (r < 6)      gap = int'($urandom_range(97, 104));
         else if (r < 8) gap = 100;
         else            gap = int'($urandom_range(1, 115));
         for (int i = 1; i < gap; i++)
            applyStimulus(1'b0, ($urandom_range(0, 49) == 0), $urandom,
                          ($urandom_range(0, 39) == 0));
         applyStimulus(1'b1, ($urandom_range(0, 3) == 0), $urandom,
                       ($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset in mid-period clears outputs without a clock edge.
      runGap(100, 1'b0, 1'b0, 32'h0);
      repeat (30) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkValue("async_reset", dutOutputs(), 68'h0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      runGap(50, 1'b0, 1'b0, 32'h0);
      checkValue("post_reset_noref_status", 68'(ifc.status_o), 68'b00);
      checkValue("post_reset_period", 68'(ifc.last_period_o), 68'd50);
      checkValue("post_reset_seconds", 68'(ifc.seconds_o), 68'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
